// File: rtl/axi_lite_reg_responder.sv
// axi_lite_reg_responder: AXI4-Lite slave with four 32-bit registers exposed on REG_OUT.
// Define AXIREG_WSTRB_EN to honour WSTRB byte lanes; otherwise every write replaces the whole register.
module axi_lite_reg_responder #(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_ADDR_WIDTH = 4
) (
  input  logic                        ACLK,
  input  logic                        ARESETN,
  input  logic [C_ADDR_WIDTH-1:0]     AWADDR,
  input  logic [2:0]                  AWPROT,
  input  logic                        AWVALID,
  output logic                        AWREADY,
  input  logic [C_DATA_WIDTH-1:0]     WDATA,
  input  logic [C_DATA_WIDTH/8-1:0]   WSTRB,
  input  logic                        WVALID,
  output logic                        WREADY,
  output logic [1:0]                  BRESP,
  output logic                        BVALID,
  input  logic                        BREADY,
  input  logic [C_ADDR_WIDTH-1:0]     ARADDR,
  input  logic [2:0]                  ARPROT,
  input  logic                        ARVALID,
  output logic                        ARREADY,
  output logic [C_DATA_WIDTH-1:0]     RDATA,
  output logic [1:0]                  RRESP,
  output logic                        RVALID,
  input  logic                        RREADY,
  output logic [4*C_DATA_WIDTH-1:0]   REG_OUT
);
  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} wstate_e;
  wstate_e state_q, state_d;
  logic ready_q;
  logic aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [1:0] awidx_q, awidx_d;
  logic [C_DATA_WIDTH-1:0] wdata_q, wdata_d, wr_val;
  logic [C_DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic [3:0][C_DATA_WIDTH-1:0] regs_q, regs_d;
  logic rvalid_q, rvalid_d;
  logic [C_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic aw_hs, w_hs, ar_hs;
  logic unused_ok;
  assign AWREADY = ready_q && state_q == W_IDLE && !aw_held_q;
  assign WREADY  = ready_q && state_q == W_IDLE && !w_held_q;
  assign ARREADY = ready_q && !rvalid_q;
  assign BVALID  = state_q == W_RESP;
  assign BRESP   = 2'b00;
  assign RVALID  = rvalid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = 2'b00;
  assign REG_OUT = regs_q;
  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;
  assign ar_hs = ARVALID && ARREADY;
  assign unused_ok = ^{AWPROT, ARPROT, AWADDR, ARADDR, wstrb_q};
`ifdef AXIREG_WSTRB_EN
  always_comb begin
    wr_val = regs_q[awidx_q];
    for (int i = 0; i < C_DATA_WIDTH/8; i++)
      if (wstrb_q[i]) wr_val[8*i +: 8] = wdata_q[8*i +: 8];
  end
`else
  assign wr_val = wdata_q;
`endif
  always_comb begin
    state_d   = state_q;
    aw_held_d = aw_hs || aw_held_q;
    w_held_d  = w_hs || w_held_q;
    awidx_d   = aw_hs ? AWADDR[3:2] : awidx_q;
    wdata_d   = w_hs ? WDATA : wdata_q;
    wstrb_d   = w_hs ? WSTRB : wstrb_q;
    regs_d    = regs_q;
    if (state_q == W_IDLE && aw_held_d && w_held_d) state_d = W_COMMIT;
    if (state_q == W_COMMIT) begin
      regs_d[awidx_q] = wr_val;
      state_d = W_RESP;
    end
    if (state_q == W_RESP && BREADY) begin
      state_d   = W_IDLE;
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end
    rvalid_d = ar_hs || (rvalid_q && !RREADY);
    rdata_d  = ar_hs ? regs_q[ARADDR[3:2]] : rdata_q;
  end
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= W_IDLE;
      ready_q   <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awidx_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      regs_q    <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= 1'b1;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awidx_q   <= awidx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      regs_q    <= regs_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end
endmodule

// File: doc/axi_lite_reg_responder.md
AXI_LITE_REG_RESPONDER -- requirements
Module: axi_lite_reg_responder

Interface
REQ-001 The block SHALL have parameter C_DATA_WIDTH, default 32, AXI data width in bits (only 32 supported).
REQ-002 The block SHALL have parameter C_ADDR_WIDTH, default 4, AXI address width in bits; register index is ADDR[3:2].
REQ-003 ACLK  input  1  single clock; all logic on rising edge.
REQ-004 ARESETN  input  1  asynchronous active-low reset.
REQ-005 AWADDR input C_ADDR_WIDTH; AWPROT input 3 (ignored); AWVALID input 1; AWREADY output 1.
REQ-006 WDATA input 32; WSTRB input 4; WVALID input 1; WREADY output 1.
REQ-007 BRESP output 2; BVALID output 1; BREADY input 1.
REQ-008 ARADDR input C_ADDR_WIDTH; ARPROT input 3 (ignored); ARVALID input 1; ARREADY output 1.
REQ-009 RDATA output 32; RRESP output 2; RVALID output 1; RREADY input 1.
REQ-010 REG_OUT  output  128  registers 3..0 concatenated, reg0 in bits [31:0].

Function
REQ-011 Write path SHALL be a 3-state FSM: W_IDLE (awaiting AW and/or W), W_COMMIT (both captured), W_RESP (BVALID high).
REQ-012 In W_IDLE, AWREADY SHALL be high until an AW handshake is captured and WREADY high until a W handshake is captured; the two are captured independently, in either order or the same cycle.
REQ-013 Once a channel's beat is captured, its READY SHALL stay low until the B handshake completes.
REQ-014 On the cycle both beats are held, FSM SHALL go to W_COMMIT; at the next edge the selected register updates and BVALID rises (write visible on REG_OUT one cycle after final handshake).
REQ-015 BVALID SHALL stay high with BRESP=2'b00 until BREADY; on the BREADY edge FSM returns to W_IDLE and AWREADY/WREADY reassert the following cycle.
REQ-016 AWADDR[1:0] and bits above [3:2] SHALL be ignored; all addresses decode to one of four registers (wrap modulo 16 bytes).
REQ-017 Read path: ARREADY SHALL be high whenever RVALID is low; on AR handshake, RDATA is loaded from the addressed register at that edge and RVALID rises next cycle.
REQ-018 RVALID and RDATA SHALL hold stable with RRESP=2'b00 until RREADY; ARREADY reasserts the cycle after the R handshake.
REQ-019 Read and write paths SHALL operate concurrently; a read whose AR handshake coincides with a same-register commit edge returns the pre-write value.
REQ-020 BVALID/RVALID SHALL never depend combinationally on BREADY/RREADY; no VALID deasserts before its handshake.

Reset
REQ-021 While ARESETN low: REG_OUT=0, RDATA=0, BRESP=RRESP=0, BVALID=RVALID=0, AWREADY=WREADY=ARREADY=0, FSM=W_IDLE.
REQ-022 READY outputs SHALL first assert on the first rising edge after ARESETN deasserts.
REQ-023 Reset mid-transaction SHALL drop any captured AW/W or pending response with no register update.

Configuration
REQ-024 With macro AXIREG_WSTRB_EN defined, only byte lanes with WSTRB[i]=1 SHALL update; other bytes keep old value.
REQ-025 Without AXIREG_WSTRB_EN, WSTRB SHALL be ignored and all four bytes written.

Verification
REQ-026 Sequential write/read 0x0101FFFF, 0xABCD0001, 0xDEAD0011, 0xBEEF0011 to 0x0,0x4,0x8,0xC -> each BRESP/RRESP=00, read data equal, REG_OUT=0xBEEF0011_DEAD0011_ABCD0001_0101FFFF.
REQ-027 W presented 3 cycles before AW at 0x4 -> WREADY low after W beat, BVALID one cycle after AW handshake, reg1 updated.
REQ-028 BREADY held low 5 cycles -> BVALID stays high, AWREADY/WREADY low; second write accepted only after B handshake.
REQ-029 reg2=0x12345678, write 0xFFFFFFFF WSTRB=4'b0101 -> 0x12FF56FF with AXIREG_WSTRB_EN, 0xFFFFFFFF without.
REQ-030 Read of 0x8 on same edge as commit of 0xCAFEF00D to 0x8 (old 0x0) -> RDATA=0x0; next read returns 0xCAFEF00D.
REQ-031 ARESETN pulsed low after AW captured, before W -> REG_OUT stays 0, no BVALID; READYs high one edge after release.
